// File: rtl/uart_pkg.sv
// Shared UART definitions: baud codes, divisor helper, parity codes, RX state enum.
package uart_pkg;

    // Baud select codes, shared with the transmit side
    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam int unsigned BAUD_2400_HZ  = 2400;
    localparam int unsigned BAUD_4800_HZ  = 4800;
    localparam int unsigned BAUD_9600_HZ  = 9600;
    localparam int unsigned BAUD_19200_HZ = 19200;

    localparam int unsigned DEFAULT_CLK_HZ     = 50_000_000;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    // Parity select codes; 2'b11 is treated as no parity
    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Oversample divisor, rounded to nearest: clk / (baud * oversample)
    function automatic logic [10:0] baud_div(input int unsigned clk_hz,
                                             input int unsigned baud_hz,
                                             input int unsigned os);
        int unsigned d;
        d = (clk_hz + (baud_hz * os) / 2) / (baud_hz * os);
        return d[10:0];
    endfunction

    // Divisors at the default 50 MHz clock: 1302, 651, 326, 163
    localparam logic [10:0] DIV_2400  = baud_div(DEFAULT_CLK_HZ, BAUD_2400_HZ,  DEFAULT_OVERSAMPLE);
    localparam logic [10:0] DIV_4800  = baud_div(DEFAULT_CLK_HZ, BAUD_4800_HZ,  DEFAULT_OVERSAMPLE);
    localparam logic [10:0] DIV_9600  = baud_div(DEFAULT_CLK_HZ, BAUD_9600_HZ,  DEFAULT_OVERSAMPLE);
    localparam logic [10:0] DIV_19200 = baud_div(DEFAULT_CLK_HZ, BAUD_19200_HZ, DEFAULT_OVERSAMPLE);

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: counts 0..div-1 and pulses tick at div-1.
module uart_rx_tick (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [10:0] div,
    output logic        tick
);

    logic [10:0] cnt;
    logic        at_end;

    assign at_end = (cnt == div - 11'd1);
    assign tick   = at_end && !clear;

    // Free-running divider, restarted by clear to align phase to the start edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled 8N1 / 8-bit-plus-parity with per-frame error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_mode,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam logic [10:0] DIV0 = baud_div(CLK_HZ, BAUD_2400_HZ,  OVERSAMPLE);
    localparam logic [10:0] DIV1 = baud_div(CLK_HZ, BAUD_4800_HZ,  OVERSAMPLE);
    localparam logic [10:0] DIV2 = baud_div(CLK_HZ, BAUD_9600_HZ,  OVERSAMPLE);
    localparam logic [10:0] DIV3 = baud_div(CLK_HZ, BAUD_19200_HZ, OVERSAMPLE);

    logic        sync1, rx_s;
    rx_state_t   state, state_n;
    logic [3:0]  scnt, scnt_n;
    logic [2:0]  bcnt, bcnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [10:0] div_q, div_n, div_sel;
    logic [1:0]  pmode_q, pmode_n;
    logic        perr_q, perr_n;
    logic [7:0]  data_n;
    logic        valid_n, perr_out_n, ferr_n;
    logic        tick, clear, parity_on;

    uart_rx_tick u_tick (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .div   (div_q),
        .tick  (tick)
    );

    assign parity_on = (pmode_q == PAR_ODD) || (pmode_q == PAR_EVEN);

    // Divisor lookup for the current baud select
    always_comb begin
        case (baud_rate)
            BAUD_2400:  div_sel = DIV0;
            BAUD_4800:  div_sel = DIV1;
            BAUD_9600:  div_sel = DIV2;
            default:    div_sel = DIV3;
        endcase
    end

    // Two-flop synchronizer on the RX pin, idles high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rx_s  <= sync1;
        end
    end

    // Next-state and next-output logic of the receive FSM
    always_comb begin
        state_n    = state;
        scnt_n     = tick ? scnt + 4'd1 : scnt;
        bcnt_n     = bcnt;
        shreg_n    = shreg;
        div_n      = div_q;
        pmode_n    = pmode_q;
        perr_n     = perr_q;
        data_n     = data_out;
        valid_n    = 1'b0;
        perr_out_n = 1'b0;
        ferr_n     = 1'b0;
        clear      = 1'b0;
        case (state)
            RX_IDLE: begin
                clear  = 1'b1;
                scnt_n = '0;
                if (!rx_s) begin
                    state_n = RX_START;
                    div_n   = div_sel;
                    pmode_n = parity_mode;
                    bcnt_n  = '0;
                    perr_n  = 1'b0;
                end
            end
            RX_START: begin
                if (tick && scnt == 4'd7) begin
                    if (!rx_s) begin
                        scnt_n  = '0;
                        state_n = RX_DATA;
                    end else begin
                        state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tick && scnt == 4'd15) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    bcnt_n  = bcnt + 3'd1;
                    if (bcnt == 3'd7) begin
                        state_n = parity_on ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (tick && scnt == 4'd15) begin
                    perr_n  = (((^shreg) ^ rx_s) != (pmode_q == PAR_ODD));
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && scnt == 4'd15) begin
                    data_n     = shreg;
                    perr_out_n = perr_q;
                    if (rx_s) begin
                        valid_n = !perr_q;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            div_q        <= DIV3;
            pmode_q      <= PAR_NONE;
            perr_q       <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            scnt         <= scnt_n;
            bcnt         <= bcnt_n;
            shreg        <= shreg_n;
            div_q        <= div_n;
            pmode_q      <= pmode_n;
            perr_q       <= perr_n;
            data_out     <= data_n;
            data_valid   <= valid_n;
            parity_error <= perr_out_n;
            frame_error  <= ferr_n;
            busy         <= (state_n != RX_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx, run with a scaled clock so frames stay short.
module tb_uart_rx;

    // 1.5625 MHz clock gives divisors 41, 20, 10, 5 for codes 00..11
    localparam int unsigned TB_CLK_HZ = 1_562_500;

    logic       clock;
    logic       reset;
    logic [1:0] baud_rate;
    logic [1:0] parity_mode;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_both = 0;
    int last_valid_cyc = 0;
    logic [7:0] last_vdata = 8'h00;
    logic [7:0] prev_vdata = 8'h00;

    uart_rx #(
        .CLK_HZ     (TB_CLK_HZ),
        .OVERSAMPLE (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .baud_rate    (baud_rate),
        .parity_mode  (parity_mode),
        .serial_in    (serial_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Cycle counter, one step per rising edge
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (data_valid) begin
            n_valid        = n_valid + 1;
            prev_vdata     = last_vdata;
            last_vdata     = data_out;
            last_valid_cyc = cyc;
        end
        if (parity_error) n_perr = n_perr + 1;
        if (frame_error) n_ferr = n_ferr + 1;
        if (data_valid && frame_error) n_both = n_both + 1;
    end

    task automatic waitc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int d);
        serial_in = b;
        waitc(16 * d);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop, input int d);
        send_bit(1'b0, d);
        for (int i = 0; i < 8; i++) send_bit(data[i], d);
        if (par_en) send_bit(par_bit, d);
        send_bit(stop, d);
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        serial_in   = 1'b1;
        baud_rate   = 2'b11;
        parity_mode = 2'b00;
        waitc(3);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected %h", data_out, 8'h00); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_error); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        waitc(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic_8n1;
        int bv, bp, bf, fall, lat;
        baud_rate   = 2'b11;
        parity_mode = 2'b00;
        bv = n_valid; bp = n_perr; bf = n_ferr;
        fall = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 5);
        waitc(10);
        lat = last_valid_cyc - fall;
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", n_valid - bv); end
        checks++; if (last_vdata !== 8'hA5) begin errors++; $display("FAIL basic_strobe_data: got %h expected a5", last_vdata); end
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data_hold: got %h expected a5", data_out); end
        checks++; if (lat < 152 * 5 + 2 || lat > 152 * 5 + 6) begin errors++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, 152 * 5 + 2, 152 * 5 + 6); end
        checks++; if (n_perr - bp !== 0 || n_ferr - bf !== 0) begin errors++; $display("FAIL basic_no_err: got perr=%0d ferr=%0d expected 0 0", n_perr - bp, n_ferr - bf); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_parity;
        int bv, bp;
        baud_rate = 2'b10;
        // even parity, correct parity bit
        parity_mode = 2'b10;
        bv = n_valid; bp = n_perr;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 10);
        waitc(160);
        checks++; if (n_valid - bv !== 1 || n_perr - bp !== 0) begin errors++; $display("FAIL even_ok: got valid=%0d perr=%0d expected 1 0", n_valid - bv, n_perr - bp); end
        checks++; if (last_vdata !== 8'h3C) begin errors++; $display("FAIL even_ok_data: got %h expected 3c", last_vdata); end
        // odd parity, 0x07 has three ones so parity bit 0 is correct
        parity_mode = 2'b01;
        bv = n_valid; bp = n_perr;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 10);
        waitc(160);
        checks++; if (n_valid - bv !== 1 || n_perr - bp !== 0) begin errors++; $display("FAIL odd_ok: got valid=%0d perr=%0d expected 1 0", n_valid - bv, n_perr - bp); end
        checks++; if (data_out !== 8'h07) begin errors++; $display("FAIL odd_ok_data: got %h expected 07", data_out); end
        // even parity, wrong parity bit
        parity_mode = 2'b10;
        bv = n_valid; bp = n_perr;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 10);
        waitc(160);
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL even_bad_valid: got %0d expected 0", n_valid - bv); end
        checks++; if (n_perr - bp !== 1) begin errors++; $display("FAIL even_bad_perr: got %0d expected 1", n_perr - bp); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL even_bad_data: got %h expected 3c", data_out); end
        parity_mode = 2'b00;
    endtask

    task automatic test_frame_error;
        int bv, bf, bp;
        baud_rate   = 2'b01;
        parity_mode = 2'b00;
        bv = n_valid; bf = n_ferr; bp = n_perr;
        send_bit(1'b0, 20);
        for (int i = 0; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 8'h00, 20);
        send_bit(1'b0, 20);
        waitc(3 * 16 * 20);
        checks++; if (n_ferr - bf !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - bf); end
        checks++; if (n_valid - bv !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", n_valid - bv); end
        checks++; if (n_perr - bp !== 0) begin errors++; $display("FAIL ferr_perr: got %0d expected 0", n_perr - bp); end
        checks++; if (data_out !== 8'h55) begin errors++; $display("FAIL ferr_data: got %h expected 55", data_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b expected 1", busy); end
        serial_in = 1'b1;
        waitc(6);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", busy); end
        waitc(320);
        bv = n_valid;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 20);
        waitc(10);
        checks++; if (n_valid - bv !== 1 || last_vdata !== 8'h81) begin errors++; $display("FAIL after_break_rx: got count=%0d data=%h expected 1 81", n_valid - bv, last_vdata); end
        checks++; if (n_ferr - bf !== 1) begin errors++; $display("FAIL after_break_ferr: got %0d expected 1", n_ferr - bf); end
    endtask

    task automatic test_glitch;
        int bv, bp, bf;
        baud_rate = 2'b11;
        bv = n_valid; bp = n_perr; bf = n_ferr;
        serial_in = 1'b0;
        waitc(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
        waitc(15);
        serial_in = 1'b1;
        waitc(5 * 8 + 4 - 20);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
        waitc(16 * 5 * 11);
        checks++; if (n_valid - bv !== 0 || n_perr - bp !== 0 || n_ferr - bf !== 0) begin errors++; $display("FAIL glitch_no_strobe: got v=%0d p=%0d f=%0d expected 0 0 0", n_valid - bv, n_perr - bp, n_ferr - bf); end
    endtask

    task automatic test_back_to_back;
        int bv, bf;
        baud_rate   = 2'b00;
        parity_mode = 2'b00;
        bv = n_valid; bf = n_ferr;
        send_bit(1'b0, 41);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) baud_rate = 2'b11;
            if (i == 6) baud_rate = 2'b00;
            send_bit(1'b0, 41);
        end
        send_bit(1'b1, 41);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 41);
        waitc(10);
        checks++; if (n_valid - bv !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_valid - bv); end
        checks++; if (prev_vdata !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", prev_vdata); end
        checks++; if (last_vdata !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", last_vdata); end
        checks++; if (n_ferr - bf !== 0 || n_both !== 0) begin errors++; $display("FAIL b2b_ferr: got ferr=%0d both=%0d expected 0 0", n_ferr - bf, n_both); end
    endtask

    task automatic test_reset_mid_frame;
        int bv, bp, bf;
        baud_rate = 2'b11;
        bv = n_valid; bp = n_perr; bf = n_ferr;
        send_bit(1'b0, 5);
        send_bit(1'b1, 5);
        send_bit(1'b0, 5);
        send_bit(1'b1, 5);
        waitc(3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data_out); end
        checks++; if (busy !== 1'b0 || data_valid !== 1'b0 || parity_error !== 1'b0 || frame_error !== 1'b0) begin errors++; $display("FAIL midrst_flags: got busy=%b v=%b p=%b f=%b expected 0 0 0 0", busy, data_valid, parity_error, frame_error); end
        serial_in = 1'b1;
        waitc(4);
        reset = 1'b0;
        waitc(16 * 5 * 12);
        checks++; if (n_valid - bv !== 0 || n_perr - bp !== 0 || n_ferr - bf !== 0) begin errors++; $display("FAIL midrst_no_strobe: got v=%0d p=%0d f=%0d expected 0 0 0", n_valid - bv, n_perr - bp, n_ferr - bf); end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 5);
        waitc(10);
        checks++; if (n_valid - bv !== 1 || last_vdata !== 8'hC3) begin errors++; $display("FAIL midrst_next: got count=%0d data=%h expected 1 c3", n_valid - bv, last_vdata); end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_frame_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
